// File: rtl/polinomio_horner.sv
// Signed polynomial evaluator using Horner's method: one shared multiplier and
// adder, sequenced IDLE -> (MUL -> ADD) x DEG, with optional saturation.
module polinomio_horner #(
  parameter int W   = 16,
  parameter int XW  = 8,
  parameter int DEG = 2,
  parameter int SAT = 0
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 START,
  input  logic [XW-1:0]        X,
  input  logic [(DEG+1)*W-1:0] COEF,
  output logic                 BUSY,
  output logic                 finished,
  output logic                 Overflow,
  output logic [W-1:0]         Resultado
);

  localparam int IW = $clog2(DEG + 1);
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

  state_t              state, state_nx;
  logic [XW-1:0]       x_r, x_nx;
  logic [DEG:0][W-1:0] coef_r, coef_nx;
  logic [W-1:0]        acc, acc_nx, prod, prod_nx, res_r, res_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic                ovf_int, ovf_int_nx, ovf_r, ovf_nx;
  logic                busy_r, busy_nx, fin_r, fin_nx;

  // Product is kept at full precision; it overflows W bits when the bits
  // above W-1 are not a pure sign extension.
  logic signed [W+XW-1:0] p;
  logic                   p_ovf;
  logic [W-1:0]           p_fit;
  logic [W-1:0]           coef_sel;
  logic [W:0]             s;
  logic                   s_ovf;
  logic [W-1:0]           s_fit;

  assign p     = $signed({{XW{acc[W-1]}}, acc}) * $signed({{W{x_r[XW-1]}}, x_r});
  assign p_ovf = ~((&p[W+XW-1:W-1]) | ~(|p[W+XW-1:W-1]));
  assign p_fit = (p_ovf && SAT != 0) ? (p[W+XW-1] ? SMIN : SMAX) : p[W-1:0];

  assign coef_sel = coef_r[idx];
  assign s        = {prod[W-1], prod} + {coef_sel[W-1], coef_sel};
  assign s_ovf    = s[W] ^ s[W-1];
  assign s_fit    = (s_ovf && SAT != 0) ? (s[W] ? SMIN : SMAX) : s[W-1:0];

  always_comb begin
    state_nx   = state;
    x_nx       = x_r;
    coef_nx    = coef_r;
    acc_nx     = acc;
    prod_nx    = prod;
    idx_nx     = idx;
    ovf_int_nx = ovf_int;
    ovf_nx     = ovf_r;
    res_nx     = res_r;
    busy_nx    = busy_r;
    fin_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          x_nx       = X;
          coef_nx    = COEF;
          acc_nx     = COEF[DEG*W +: W];
          idx_nx     = IW'(DEG - 1);
          ovf_int_nx = 1'b0;
          busy_nx    = 1'b1;
          state_nx   = MUL;
        end
      end
      MUL: begin
        prod_nx = p_fit;
        if (p_ovf) ovf_int_nx = 1'b1;
        state_nx = ADD;
      end
      ADD: begin
        acc_nx = s_fit;
        if (s_ovf) ovf_int_nx = 1'b1;
        if (idx == '0) begin
          res_nx   = s_fit;
          ovf_nx   = ovf_int | s_ovf;
          fin_nx   = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          idx_nx   = idx - IW'(1);
          state_nx = MUL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= IDLE;
      x_r     <= '0;
      coef_r  <= '0;
      acc     <= '0;
      prod    <= '0;
      idx     <= '0;
      ovf_int <= 1'b0;
      ovf_r   <= 1'b0;
      res_r   <= '0;
      busy_r  <= 1'b0;
      fin_r   <= 1'b0;
    end else begin
      state   <= state_nx;
      x_r     <= x_nx;
      coef_r  <= coef_nx;
      acc     <= acc_nx;
      prod    <= prod_nx;
      idx     <= idx_nx;
      ovf_int <= ovf_int_nx;
      ovf_r   <= ovf_nx;
      res_r   <= res_nx;
      busy_r  <= busy_nx;
      fin_r   <= fin_nx;
    end
  end

  assign BUSY      = busy_r;
  assign finished  = fin_r;
  assign Overflow  = ovf_r;
  assign Resultado = res_r;

endmodule
